// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and rotor arithmetic helpers for the rotor sequencer.
// Feature macro: ENIGMA_DOUBLE_STEP_EN (consumed by enigma_rotor_stepper).
package enigma_pkg;

    localparam int unsigned ENIGMA_ALPHA  = 26;
    localparam int unsigned ENIGMA_NOTCH0 = 16;
    localparam int unsigned ENIGMA_NOTCH1 = 4;
    localparam int unsigned ENIGMA_NOTCH2 = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_WAIT,
        ST_HOLD
    } seq_state_t;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input int unsigned alpha);
        return (32'(v) + 32'd1 >= alpha) ? '0 : v + 6'd1;
    endfunction

    // Inverse offset seen by the backward path: (alpha - v) mod alpha.
    function automatic logic [5:0] inv_pos(input logic [5:0] v, input int unsigned alpha);
        return (v == '0) ? '0 : 6'(alpha - 32'(v));
    endfunction

    function automatic logic [5:0] clamp_pos(input logic [5:0] v, input int unsigned alpha);
        return (32'(v) < alpha) ? v : '0;
    endfunction

endpackage

// File: rtl/enigma_rotor_stepper.sv
// Combinational next-position and inverse-offset logic for the three rotors.
// ENIGMA_DOUBLE_STEP_EN selects the historical double-step; otherwise a pure odometer.
module enigma_rotor_stepper
    import enigma_pkg::*;
#(
    parameter int unsigned ALPHA  = ENIGMA_ALPHA,
    parameter int unsigned NOTCH0 = ENIGMA_NOTCH0,
    parameter int unsigned NOTCH1 = ENIGMA_NOTCH1
) (
    input  logic [5:0] i_pos0,
    input  logic [5:0] i_pos1,
    input  logic [5:0] i_pos2,
    output logic [5:0] o_next0,
    output logic [5:0] o_next1,
    output logic [5:0] o_next2,
    output logic [5:0] o_inv0,
    output logic [5:0] o_inv1,
    output logic [5:0] o_inv2
);

    logic w_at0;
    logic w_at1;
    logic w_step1;
    logic w_step2;

    always_comb begin
        w_at0 = (32'(i_pos0) == NOTCH0);
        w_at1 = (32'(i_pos1) == NOTCH1);
`ifdef ENIGMA_DOUBLE_STEP_EN
        // Rotor 1 sitting on its notch drags itself and rotor 2 forward.
        w_step1 = w_at0 || w_at1;
        w_step2 = w_at1;
`else
        w_step1 = w_at0;
        w_step2 = w_at1 && w_at0;
`endif
        o_next0 = wrap_inc(i_pos0, ALPHA);
        o_next1 = w_step1 ? wrap_inc(i_pos1, ALPHA) : i_pos1;
        o_next2 = w_step2 ? wrap_inc(i_pos2, ALPHA) : i_pos2;
        o_inv0  = inv_pos(o_next0, ALPHA);
        o_inv1  = inv_pos(o_next1, ALPHA);
        o_inv2  = inv_pos(o_next2, ALPHA);
    end

endmodule

// File: rtl/enigma_rotor_sequencer.sv
// Per-character rotor stepping and handshake controller for the stateless Enigma datapath.
// Stepping rule selected by ENIGMA_DOUBLE_STEP_EN (see enigma_rotor_stepper).
module enigma_rotor_sequencer
    import enigma_pkg::*;
#(
    parameter int unsigned ALPHA  = ENIGMA_ALPHA,
    parameter int unsigned NOTCH0 = ENIGMA_NOTCH0,
    parameter int unsigned NOTCH1 = ENIGMA_NOTCH1,
    parameter int unsigned NOTCH2 = ENIGMA_NOTCH2,
    parameter int unsigned DP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_load,
    input  logic [5:0]  cfg_pos0,
    input  logic [5:0]  cfg_pos1,
    input  logic [5:0]  cfg_pos2,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_char,
    output logic [5:0]  dp_data_in,
    input  logic [5:0]  dp_data_out,
    output logic [5:0]  r0_positionF,
    output logic [5:0]  r1_positionF,
    output logic [5:0]  r2_positionF,
    output logic [5:0]  r0_positionB,
    output logic [5:0]  r1_positionB,
    output logic [5:0]  r2_positionB,
    output logic [15:0] char_cnt,
    output logic        busy
);

    seq_state_t  r_state;
    logic [5:0]  r_pos0, r_pos1, r_pos2;
    logic [5:0]  r_inv0, r_inv1, r_inv2;
    logic [5:0]  r_dp_in;
    logic [5:0]  r_out_char;
    logic        r_out_valid;
    logic [15:0] r_char_cnt;
    logic [15:0] r_settle;

    logic [5:0]  w_next0, w_next1, w_next2;
    logic [5:0]  w_inv0, w_inv1, w_inv2;
    logic [5:0]  w_ld0, w_ld1, w_ld2;

    enigma_rotor_stepper #(
        .ALPHA  (ALPHA),
        .NOTCH0 (NOTCH0),
        .NOTCH1 (NOTCH1)
    ) u_stepper (
        .i_pos0  (r_pos0),
        .i_pos1  (r_pos1),
        .i_pos2  (r_pos2),
        .o_next0 (w_next0),
        .o_next1 (w_next1),
        .o_next2 (w_next2),
        .o_inv0  (w_inv0),
        .o_inv1  (w_inv1),
        .o_inv2  (w_inv2)
    );

    assign w_ld0 = clamp_pos(cfg_pos0, ALPHA);
    assign w_ld1 = clamp_pos(cfg_pos1, ALPHA);
    assign w_ld2 = clamp_pos(cfg_pos2, ALPHA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pos0      <= '0;
            r_pos1      <= '0;
            r_pos2      <= '0;
            r_inv0      <= '0;
            r_inv1      <= '0;
            r_inv2      <= '0;
            r_dp_in     <= '0;
            r_out_char  <= '0;
            r_out_valid <= 1'b0;
            r_char_cnt  <= '0;
            r_settle    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        r_pos0     <= w_ld0;
                        r_pos1     <= w_ld1;
                        r_pos2     <= w_ld2;
                        r_inv0     <= inv_pos(w_ld0, ALPHA);
                        r_inv1     <= inv_pos(w_ld1, ALPHA);
                        r_inv2     <= inv_pos(w_ld2, ALPHA);
                        r_char_cnt <= '0;
                    end else if (in_valid) begin
                        r_dp_in <= in_char;
                        r_state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_pos0   <= w_next0;
                    r_pos1   <= w_next1;
                    r_pos2   <= w_next2;
                    r_inv0   <= w_inv0;
                    r_inv1   <= w_inv1;
                    r_inv2   <= w_inv2;
                    r_settle <= 16'(DP_LAT);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture on the edge where the settle count sits at 1.
                    if (r_settle == 16'd1) begin
                        r_out_char  <= dp_data_out;
                        r_out_valid <= 1'b1;
                        r_char_cnt  <= r_char_cnt + 16'd1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_settle <= r_settle - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign out_valid    = r_out_valid;
    assign out_char     = r_out_char;
    assign dp_data_in   = r_dp_in;
    assign r0_positionF = r_pos0;
    assign r1_positionF = r_pos1;
    assign r2_positionF = r_pos2;
    assign r0_positionB = r_inv0;
    assign r1_positionB = r_inv1;
    assign r2_positionB = r_inv2;
    assign char_cnt     = r_char_cnt;

endmodule
